// File: rtl/sent_rx_frame_buffer_pkg.sv
// Shared record definitions for the SENT receive frame buffer: type codes,
// field positions and packing helpers for fast, slow and timeout records.
package sent_rx_pkg;

    localparam int unsigned REC_W = 32;

    typedef enum logic [1:0] {
        REC_NONE    = 2'b00,
        REC_FAST    = 2'b01,
        REC_SLOW    = 2'b10,
        REC_TIMEOUT = 2'b11
    } rec_type_e;

    // Source selected for the single buffer write port in a given cycle
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FAST,
        SRC_TIMEOUT,
        SRC_SLOW
    } wr_src_e;

    localparam int unsigned TYPE_MSB       = 31;
    localparam int unsigned TYPE_LSB       = 30;
    localparam int unsigned FAST_PAUSE_BIT = 12;
    localparam int unsigned FAST_DATA_MSB  = 11;
    localparam int unsigned SLOW_ID_MSB    = 27;
    localparam int unsigned SLOW_ID_LSB    = 20;
    localparam int unsigned SLOW_CFG_BIT   = 17;
    localparam int unsigned SLOW_FMT_BIT   = 16;
    localparam int unsigned SLOW_DATA_MSB  = 15;

    function automatic logic [REC_W-1:0] pack_fast(input logic pause, input logic [11:0] data);
        logic [REC_W-1:0] r;
        r = '0;
        r[TYPE_MSB:TYPE_LSB]  = REC_FAST;
        r[FAST_PAUSE_BIT]     = pause;
        r[FAST_DATA_MSB:0]    = data;
        return r;
    endfunction

    function automatic logic [REC_W-1:0] pack_slow(input logic [7:0] id, input logic config_bit,
                                                   input logic channel_format, input logic [15:0] data);
        logic [REC_W-1:0] r;
        r = '0;
        r[TYPE_MSB:TYPE_LSB]       = REC_SLOW;
        r[SLOW_ID_MSB:SLOW_ID_LSB] = id;
        r[SLOW_CFG_BIT]            = config_bit;
        r[SLOW_FMT_BIT]            = channel_format;
        r[SLOW_DATA_MSB:0]         = data;
        return r;
    endfunction

    function automatic logic [REC_W-1:0] pack_timeout();
        logic [REC_W-1:0] r;
        r = '0;
        r[TYPE_MSB:TYPE_LSB] = REC_TIMEOUT;
        return r;
    endfunction

endpackage

// File: rtl/sent_rx_frame_buffer_if.sv
// Host-side record stream: valid/ready handshake carrying one 32-bit record.
interface sent_rx_frame_buffer_if;
    import sent_rx_pkg::*;

    logic             rec_valid_o;
    logic             rec_ready_i;
    logic [REC_W-1:0] rec_data_o;

    modport master (output rec_valid_o, output rec_data_o, input rec_ready_i);
    modport slave  (input rec_valid_o, input rec_data_o, output rec_ready_i);

endinterface

// File: rtl/sent_rx_sync_fifo.sv
// Single-clock circular buffer whose head entry is held in a register so the
// consumer sees a flop output; a push into an empty buffer appears next cycle.
module sent_rx_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    import sent_rx_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_next    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // The next head comes from the write port when it lands on the slot
    // about to become the head (empty buffer, or single entry being popped).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0) begin
                head <= (do_push && (wr_ptr == rd_next)) ? wdata : mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/sent_rx_frame_buffer.sv
// Packs SENT fast frames, slow-serial messages and link-loss events into
// 32-bit records and queues them for the host; tracks drops and link timeout.
module sent_rx_frame_buffer
    import sent_rx_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned DROP_W         = 8
) (
    input  logic                       clk_rx,
    input  logic                       reset_rx,
    input  logic                       write_enable_rx_i,
    input  logic [11:0]                data_fast_i,
    input  logic                       pause_received_i,
    input  logic                       serial_valid_i,
    input  logic [7:0]                 id_received_i,
    input  logic [15:0]                data_received_i,
    input  logic                       channel_format_received_i,
    input  logic                       config_bit_received_i,
    sent_rx_frame_buffer_if.master     rec_if,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [DROP_W-1:0]          drop_count_o,
    output logic                       link_lost_o,
    input  logic                       clear_status_i
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic [REC_W-1:0] fifo_wdata;
    logic [REC_W-1:0] fifo_head;
    logic             rec_valid;
    logic             pop;
    logic             can_accept;

    logic             slow_pending_q;
    logic [REC_W-1:0] slow_rec_q;
    logic             timeout_req_q;
    logic [TW-1:0]    timer_q;

    wr_src_e          wr_src;
    logic             slow_drain;
    logic             drop_main;
    logic             drop_slow;
    logic [DROP_W-1:0] drop_base;
    logic [DROP_W:0]  drop_sum;

    sent_rx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk_rx),
        .rst   (reset_rx),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign rec_valid         = !fifo_empty;
    assign rec_if.rec_valid_o = rec_valid;
    assign rec_if.rec_data_o  = fifo_head;

    always_comb begin
        pop        = rec_valid && rec_if.rec_ready_i;
        can_accept = !fifo_full || pop;

        wr_src = SRC_NONE;
        if (write_enable_rx_i) begin
            wr_src = SRC_FAST;
        end else if (timeout_req_q) begin
            wr_src = SRC_TIMEOUT;
        end else if (slow_pending_q && !fifo_full) begin
            wr_src = SRC_SLOW;
        end
        slow_drain = (wr_src == SRC_SLOW);

        fifo_wdata = '0;
        case (wr_src)
            SRC_FAST:    fifo_wdata = pack_fast(pause_received_i, data_fast_i);
            SRC_TIMEOUT: fifo_wdata = pack_timeout();
            SRC_SLOW:    fifo_wdata = slow_rec_q;
            default:     fifo_wdata = '0;
        endcase

        fifo_push = (wr_src != SRC_NONE) && can_accept;
        drop_main = ((wr_src == SRC_FAST) || (wr_src == SRC_TIMEOUT)) && !can_accept;
        drop_slow = serial_valid_i && slow_pending_q && !slow_drain;

        // A fast drop and a slot overwrite can coincide; both are counted.
        drop_base = clear_status_i ? '0 : drop_count_o;
        drop_sum  = {1'b0, drop_base} + (DROP_W+1)'(drop_main) + (DROP_W+1)'(drop_slow);
    end

    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            slow_pending_q <= 1'b0;
            slow_rec_q     <= '0;
            timeout_req_q  <= 1'b0;
            timer_q        <= '0;
            link_lost_o    <= 1'b0;
            overflow_o     <= 1'b0;
            drop_count_o   <= '0;
        end else begin
            if (serial_valid_i) begin
                slow_pending_q <= 1'b1;
                slow_rec_q     <= pack_slow(id_received_i, config_bit_received_i,
                                            channel_format_received_i, data_received_i);
            end else if (slow_drain) begin
                slow_pending_q <= 1'b0;
            end

            if (wr_src == SRC_TIMEOUT) begin
                timeout_req_q <= 1'b0;
            end

            // Timer parks at its last value so one loss episode raises one request.
            if (write_enable_rx_i) begin
                timer_q     <= '0;
                link_lost_o <= 1'b0;
            end else if (timer_q != TIMER_LAST) begin
                timer_q <= timer_q + TW'(1);
            end else if (!link_lost_o) begin
                link_lost_o   <= 1'b1;
                timeout_req_q <= 1'b1;
            end

            overflow_o   <= drop_main || drop_slow || (overflow_o && !clear_status_i);
            drop_count_o <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

endmodule
